// File: rtl/dla_reset_sequencer.sv
// Reset combiner/sequencer: merges synchronised reset sources and a software request,
// holds the combined reset, then releases the output domains in order with sticky cause/count status.
module dla_reset_sequencer #(
   parameter int                     NUM_SOURCES        = 4,
   parameter int                     NUM_OUTPUTS        = 3,
   parameter int                     HOLD_CYCLES        = 256,
   parameter int                     STAGGER_CYCLES     = 16,
   parameter logic [NUM_SOURCES-1:0] SOURCE_ENABLE_MASK = '1
) (
   input  logic                   clk,
   input  logic                   i_resetn,
   input  logic [NUM_SOURCES-1:0] i_resetn_sources,
   input  logic                   i_sw_reset_req,
   input  logic                   i_cause_clear,
   output logic [NUM_OUTPUTS-1:0] o_resetn,
   output logic                   o_reset_active,
   output logic [NUM_SOURCES:0]   o_reset_cause,
   output logic [7:0]             o_reset_count
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);

   typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

   state_t                 state;
   logic [NUM_SOURCES-1:0] sync_q1, sync_q2;
   logic [HW-1:0]          hold_cnt;
   logic [SW-1:0]          stag_cnt;
   logic                   ok;
   logic [NUM_SOURCES:0]   cause_new;
   logic [NUM_OUTPUTS-1:0] rel_next;

   // Disabled sources are forced "good"; the software request bypasses the synchroniser.
   assign ok        = (&(sync_q2 | ~SOURCE_ENABLE_MASK)) & ~i_sw_reset_req;
   assign cause_new = {i_sw_reset_req, ~sync_q2 & SOURCE_ENABLE_MASK};
   assign rel_next  = (o_resetn << 1) | NUM_OUTPUTS'(1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge i_resetn) begin
      if (!i_resetn) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= i_resetn_sources;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state          <= ST_ASSERT;
         hold_cnt       <= '0;
         stag_cnt       <= '0;
         o_resetn       <= '0;
         o_reset_active <= 1'b1;
         o_reset_cause  <= '0;
         o_reset_count  <= '0;
      end else begin
         if (i_cause_clear) o_reset_cause <= '0;

         case (state)
            ST_ASSERT: begin
               o_resetn <= '0;
               if (!ok) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= '0;
                  stag_cnt <= '0;
                  o_resetn <= NUM_OUTPUTS'(1);
                  if (NUM_OUTPUTS == 1) begin
                     state          <= ST_RUN;
                     o_reset_active <= 1'b0;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            ST_RELEASE, ST_RUN: begin
               if (!ok) begin
                  // Re-entry from a released state: capture cause (new event wins over clear).
                  state          <= ST_ASSERT;
                  hold_cnt       <= '0;
                  o_resetn       <= '0;
                  o_reset_active <= 1'b1;
                  o_reset_cause  <= (i_cause_clear ? '0 : o_reset_cause) | cause_new;
                  if (o_reset_count != 8'hFF) o_reset_count <= o_reset_count + 8'd1;
               end else if (state == ST_RELEASE) begin
                  if (stag_cnt == STAG_LAST) begin
                     stag_cnt <= '0;
                     o_resetn <= rel_next;
                     if (rel_next[NUM_OUTPUTS-1]) begin
                        state          <= ST_RUN;
                        o_reset_active <= 1'b0;
                     end
                  end else begin
                     stag_cnt <= stag_cnt + 1'b1;
                  end
               end
            end

            default: begin
               state    <= ST_ASSERT;
               o_resetn <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dla_reset_sequencer.sv
// Self-checking bench: a streak-based model of the sequencer checked every cycle,
// plus directed literal expectations for the release timing and status registers.
module tb_dla_reset_sequencer;

   localparam int NS   = 4;
   localparam int NO   = 3;
   localparam int HOLD = 8;
   localparam int STAG = 4;

   logic          clk = 1'b0;
   logic          i_resetn;
   logic [NS-1:0] src;
   logic          sw_req;
   logic          cause_clear;
   logic [NO-1:0] rst_out;
   logic          active;
   logic [NS:0]   cause;
   logic [7:0]    count;

   logic [NS-1:0] src_m;
   logic          sw_m;
   logic          clear_m;
   logic [NO-1:0] rst_out_m;
   logic          active_m;
   logic [NS:0]   cause_m;
   logic [7:0]    count_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dla_reset_sequencer #(
      .NUM_SOURCES(NS), .NUM_OUTPUTS(NO), .HOLD_CYCLES(HOLD),
      .STAGGER_CYCLES(STAG), .SOURCE_ENABLE_MASK(4'b1111)
   ) dut (
      .clk(clk), .i_resetn(i_resetn), .i_resetn_sources(src),
      .i_sw_reset_req(sw_req), .i_cause_clear(cause_clear),
      .o_resetn(rst_out), .o_reset_active(active),
      .o_reset_cause(cause), .o_reset_count(count)
   );

   dla_reset_sequencer #(
      .NUM_SOURCES(NS), .NUM_OUTPUTS(NO), .HOLD_CYCLES(HOLD),
      .STAGGER_CYCLES(STAG), .SOURCE_ENABLE_MASK(4'b1011)
   ) dut_m (
      .clk(clk), .i_resetn(i_resetn), .i_resetn_sources(src_m),
      .i_sw_reset_req(sw_m), .i_cause_clear(clear_m),
      .o_resetn(rst_out_m), .o_reset_active(active_m),
      .o_reset_cause(cause_m), .o_reset_count(count_m)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: output k is released once ok has held for HOLD + k*STAG consecutive edges.
   logic [NS-1:0] h1, h2;
   int            streak;
   int            m_count;
   logic [NS:0]   m_cause;
   logic          m_ok;
   logic [NS:0]   m_base;

   always @(posedge clk or negedge i_resetn) begin
      if (!i_resetn) begin
         h1 = '0; h2 = '0; streak = 0; m_count = 0; m_cause = '0;
      end else begin
         m_ok   = (h2 == {NS{1'b1}}) && !sw_req;
         m_base = cause_clear ? '0 : m_cause;
         if (!m_ok && streak >= HOLD) begin
            m_cause = m_base | {sw_req, ~h2};
            if (m_count < 255) m_count++;
         end else begin
            m_cause = m_base;
         end
         streak = m_ok ? ((streak < 1000000) ? streak + 1 : streak) : 0;
         h2 = h1;
         h1 = src;
      end
   end

   always @(negedge clk) begin
      logic [NO-1:0] e;
      for (int k = 0; k < NO; k++) e[k] = (streak >= HOLD + k * STAG);
      check("model o_resetn", 32'(rst_out), 32'(e));
      check("model o_reset_active", 32'(active), 32'(streak < HOLD + (NO - 1) * STAG));
      check("model o_reset_cause", 32'(cause), 32'(m_cause));
      check("model o_reset_count", 32'(count), 32'(m_count));
   end

   initial begin
      i_resetn = 1'b0; src = '1; sw_req = 1'b0; cause_clear = 1'b0;
      src_m = 4'b1011; sw_m = 1'b0; clear_m = 1'b0;
      tick(3);
      check("reset o_resetn", 32'(rst_out), 32'h0);
      check("reset active", 32'(active), 32'h1);
      check("reset cause", 32'(cause), 32'h0);
      check("reset count", 32'(count), 32'h0);

      // Power-up release: edges 10, 14, 18.
      i_resetn = 1'b1;
      tick(9);  check("pwr edge9", 32'(rst_out), 32'b000);
      tick(1);  check("pwr edge10", 32'(rst_out), 32'b001);
                check("mask edge10", 32'(rst_out_m), 32'b001);
      tick(3);  check("pwr edge13", 32'(rst_out), 32'b001);
      tick(1);  check("pwr edge14", 32'(rst_out), 32'b011);
      tick(3);  check("pwr edge17", 32'(rst_out), 32'b011);
                check("pwr active17", 32'(active), 32'h1);
      tick(1);  check("pwr edge18", 32'(rst_out), 32'b111);
                check("pwr active18", 32'(active), 32'h0);
                check("pwr cause", 32'(cause), 32'h0);
                check("pwr count", 32'(count), 32'h0);
                check("mask edge18", 32'(rst_out_m), 32'b111);
                check("mask active18", 32'(active_m), 32'h0);

      // Source 2 low for three cycles from RUN.
      src[2] = 1'b0;
      tick(2);  check("src2 edge2", 32'(rst_out), 32'b111);
      tick(1);  check("src2 edge3", 32'(rst_out), 32'b000);
                check("src2 cause", 32'(cause), 32'b00100);
                check("src2 count", 32'(count), 32'd1);
      src[2] = 1'b1;
      // Pulse source 1 while the hold counter sits at 5.
      tick(7);
      src[1] = 1'b0;
      tick(2);
      src[1] = 1'b1;
      tick(1);  check("glitch edge13", 32'(rst_out), 32'b000);
      tick(8);  check("glitch edge21", 32'(rst_out), 32'b000);
      tick(1);  check("glitch edge22", 32'(rst_out), 32'b001);
                check("glitch cause", 32'(cause), 32'b00100);
                check("glitch count", 32'(count), 32'd1);
      tick(8);  check("glitch edge30", 32'(rst_out), 32'b111);

      // Clear cause, then build a source-0 cause.
      cause_clear = 1'b1;
      tick(1);  cause_clear = 1'b0;
                check("clear cause", 32'(cause), 32'h0);
      src[0] = 1'b0;
      tick(2);  src[0] = 1'b1;
      tick(1);  check("src0 cause", 32'(cause), 32'b00001);
                check("src0 count", 32'(count), 32'd2);
      tick(20); check("src0 rerun", 32'(active), 32'h0);

      // Software request with a simultaneous clear: new event wins.
      sw_req = 1'b1; cause_clear = 1'b1;
      tick(1);  sw_req = 1'b0; cause_clear = 1'b0;
                check("sw o_resetn", 32'(rst_out), 32'b000);
                check("sw cause", 32'(cause), 32'b10000);
                check("sw count", 32'(count), 32'd3);
      tick(7);  check("sw edge8", 32'(rst_out), 32'b000);
      tick(1);  check("sw edge9", 32'(rst_out), 32'b001);
      tick(10);

      // Repeated source events saturate the counter.
      for (int i = 0; i < 300; i++) begin
         src[0] = 1'b0;
         tick(2);
         src[0] = 1'b1;
         tick(12);
      end
      check("count saturated", 32'(count), 32'd255);
      check("mask cause", 32'(cause_m), 32'h0);
      check("mask count", 32'(count_m), 32'h0);

      // Async reset in the middle of RELEASE.
      src[0] = 1'b0;
      tick(2);  src[0] = 1'b1;
      tick(12); check("mid release", 32'(rst_out), 32'b001);
      i_resetn = 1'b0;
      #1;
      check("async o_resetn", 32'(rst_out), 32'h0);
      check("async active", 32'(active), 32'h1);
      check("async cause", 32'(cause), 32'h0);
      check("async count", 32'(count), 32'h0);
      tick(2);
      i_resetn = 1'b1;
      tick(20);
      check("repower active", 32'(active), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dla_reset_sequencer.md
Name: dla_reset_sequencer

Overview:
Parametrised reset combiner and sequencer for the DLA platform. It merges NUM_SOURCES asynchronous active-low reset sources plus a synchronous software reset request, and holds the combined reset for HOLD_CYCLES. It then releases NUM_OUTPUTS reset domains in a fixed order, STAGGER_CYCLES apart, and records sticky reset-cause and reset-count status for CSR readback. The block sits between the platform reset inputs and the per-subsystem reset distribution.

Parameters:
NUM_SOURCES, 4, number of external active-low reset sources (1..16)
NUM_OUTPUTS, 3, number of sequenced reset outputs (1..8)
HOLD_CYCLES, 256, cycles every enabled source must be high before the first release (>=1)
STAGGER_CYCLES, 16, cycles between consecutive output releases (>=1)
SOURCE_ENABLE_MASK, all ones, bit i=0 means source i is ignored

Ports:
clk  input  1  block clock
i_resetn  input  1  asynchronous active-low reset
i_resetn_sources  input  NUM_SOURCES  async active-low reset sources, synchronised internally
i_sw_reset_req  input  1  synchronous to clk, level-sensitive, active-high software reset
i_cause_clear  input  1  single-cycle pulse that clears o_reset_cause
o_resetn  output  NUM_OUTPUTS  sequenced active-low resets; bit 0 is released first
o_reset_active  output  1  high whenever the FSM is not in RUN
o_reset_cause  output  NUM_SOURCES+1  sticky causes; bit i = source i, bit NUM_SOURCES = software request
o_reset_count  output  8  saturating count of re-entries into ASSERT

Behaviour:
- Reset values: o_resetn all 0, o_reset_active 1, o_reset_cause 0, o_reset_count 0, FSM in ASSERT, hold counter 0, synchroniser flops 0.
- Each source passes through a 2-flop synchroniser. The synchroniser flops are async-cleared by i_resetn.
- ok = AND over i of (synced[i] | ~SOURCE_ENABLE_MASK[i]) AND ~i_sw_reset_req.
- ASSERT state:
  - all o_resetn held 0.
  - cnt increments on each cycle where ok=1 and clears to 0 on each cycle where ok=0.
  - When ok=1 and cnt==HOLD_CYCLES-1, move to RELEASE and set o_resetn[0]=1 on that same edge.
  - If NUM_OUTPUTS==1, move straight to RUN instead.
- RELEASE state:
  - The stagger counter counts ok cycles.
  - Every STAGGER_CYCLES cycles the next o_resetn bit is set.
  - o_resetn[k] rises exactly k*STAGGER_CYCLES cycles after o_resetn[0].
  - The edge that releases the last bit also enters RUN.
- RUN state: all o_resetn=1 and o_reset_active=0.
- ok=0 in RELEASE or RUN:
  - On the next edge, all o_resetn go to 0, the FSM enters ASSERT and cnt clears.
  - o_reset_count increments and saturates at 255.
  - o_reset_cause |= the vector of enabled sources whose synced value is low in that cycle, plus the sw bit if the request is high.
- ok=0 while already in ASSERT: restarts the hold count only. The cause register and count are not updated.
- Source glitches: a source glitch shorter than one clock may be missed. A low level lasting 2 or more cycles is always captured.
- Disabled sources: never affect ok and never set a cause bit.
- i_cause_clear:
  - Clears o_reset_cause on the next edge.
  - If a capture happens on the same edge, the result is exactly the newly captured bits (new event wins).
- o_resetn bits, o_reset_active, o_reset_cause and o_reset_count are all registered, with no combinational path from any input.
- i_resetn assertion mid-sequence immediately returns every output to its reset value.

Test Plan:
1. Power-up release with NUM_SOURCES=4, NUM_OUTPUTS=3, HOLD_CYCLES=8, STAGGER_CYCLES=4, all sources high. Deassert i_resetn -> o_resetn[0] rises at clk edge 10, [1] at edge 14, [2] at edge 18. o_reset_active falls at edge 18. Cause=0 and count=0.
2. In RUN, drive source 2 low for 3 cycles -> all o_resetn reach 0 within 3 edges (2 sync plus 1 register). Cause=5'b00100, count=1. The release sequence repeats 8 cycles after source 2 is synced high.
3. In ASSERT at cnt=5, pulse source 1 low for 2 cycles -> cnt restarts from 0 and o_resetn[0] is delayed accordingly. Cause and count are unchanged.
4. SOURCE_ENABLE_MASK=4'b1011, source 2 held low -> the sequence completes normally. Cause bit 2 never sets.
5. In RUN, assert i_sw_reset_req for 1 cycle together with i_cause_clear while the old cause is 5'b00001 -> cause=5'b10000, count increments, and re-release begins 8 cycles later.
6. Toggle a source 300 times from RUN -> o_reset_count saturates at 255. Then assert i_resetn mid-RELEASE -> all outputs return to reset values immediately.
